// File: rtl/mips_data_mem_arbiter.sv
// Shares the data memory port between the CPU data side and a DMA/loader requester.
// Define MIPS_ARB_STARVE_EN to enable the starvation counter and one-cycle CPU freeze (STEAL).
module mips_data_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_enable_i,
    output logic        cpu_clk_enable_o,
    input  logic [31:0] cpu_data_address_i,
    input  logic        cpu_data_write_i,
    input  logic        cpu_data_read_i,
    input  logic [31:0] cpu_data_writedata_i,
    output logic [31:0] cpu_data_readdata_o,
    input  logic        dma_req_i,
    input  logic        dma_write_i,
    input  logic [31:0] dma_address_i,
    input  logic [31:0] dma_writedata_i,
    output logic [31:0] dma_readdata_o,
    output logic        dma_ack_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_writedata_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic        mem_clk_enable_o,
    input  logic [31:0] mem_readdata_i
);

`ifdef MIPS_ARB_STARVE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEAL = 2'd1, S_ACK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] dma_readdata_q;
    logic        dma_grant;
    logic        cpu_busy;

`ifdef MIPS_ARB_STARVE_EN
    logic [7:0]  starve_cnt_q, starve_cnt_d;
`endif

    assign cpu_busy = cpu_data_read_i | cpu_data_write_i;

    always_comb begin
        state_d   = state_q;
        dma_grant = 1'b0;
`ifdef MIPS_ARB_STARVE_EN
        starve_cnt_d = starve_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!dma_req_i) begin
`ifdef MIPS_ARB_STARVE_EN
                    starve_cnt_d = 8'd0;
`endif
                end else if (!cpu_busy) begin
                    dma_grant = 1'b1;
                    state_d   = S_ACK;
`ifdef MIPS_ARB_STARVE_EN
                    starve_cnt_d = 8'd0;
`endif
                end else begin
`ifdef MIPS_ARB_STARVE_EN
                    // Contended: the CPU keeps the port until the DMA has waited long enough.
                    if (starve_cnt_q == 8'(STARVE_LIMIT - 1)) begin
                        state_d = S_STEAL;
                    end else begin
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    end
`endif
                end
            end
`ifdef MIPS_ARB_STARVE_EN
            S_STEAL: begin
                dma_grant    = 1'b1;
                starve_cnt_d = 8'd0;
                state_d      = S_ACK;
            end
`endif
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            dma_readdata_q <= 32'd0;
`ifdef MIPS_ARB_STARVE_EN
            starve_cnt_q   <= 8'd0;
`endif
        end else if (clk_enable_i) begin
            state_q <= state_d;
`ifdef MIPS_ARB_STARVE_EN
            starve_cnt_q <= starve_cnt_d;
`endif
            if (dma_grant && !dma_write_i) begin
                dma_readdata_q <= mem_readdata_i;
            end
        end
    end

    assign mem_address_o       = dma_grant ? dma_address_i   : cpu_data_address_i;
    assign mem_writedata_o     = dma_grant ? dma_writedata_i : cpu_data_writedata_i;
    assign mem_write_o         = dma_grant ? dma_write_i     : cpu_data_write_i;
    assign mem_read_o          = dma_grant ? !dma_write_i    : cpu_data_read_i;
    assign mem_clk_enable_o    = clk_enable_i;
    assign cpu_data_readdata_o = mem_readdata_i;
    assign dma_readdata_o      = dma_readdata_q;
    assign dma_ack_o           = (state_q == S_ACK);

`ifdef MIPS_ARB_STARVE_EN
    assign cpu_clk_enable_o = clk_enable_i & (state_q != S_STEAL);
`else
    assign cpu_clk_enable_o = clk_enable_i;
`endif

endmodule

// File: doc/mips_data_mem_arbiter.md
# mips_data_mem_arbiter

Shares the single data memory port between the MIPS Harvard CPU data interface and a secondary loader/DMA requester. The CPU always wins contended cycles because its data interface has no stall input; the DMA port waits on a request/ack handshake. A starvation counter can freeze the CPU for one cycle via its clock enable so the DMA access completes. Sits between `mips_cpu_harvard` (data side), the DMA/loader, and `mips_cpu_data_memory`.

## Interface
- STARVE_LIMIT, 4: contended cycles a pending DMA request tolerates before a steal (range 1..255).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clk_enable  in  1  global enable; 0 freezes all state.
- cpu_clk_enable  out  1  clock enable driven to the CPU.
- cpu_data_address  in  32  CPU data address.
- cpu_data_write  in  1  CPU write strobe.
- cpu_data_read  in  1  CPU read strobe.
- cpu_data_writedata  in  32  CPU write data.
- cpu_data_readdata  out  32  equals mem_readdata, combinational.
- dma_req  in  1  DMA request; held until dma_ack.
- dma_write  in  1  1 = write, 0 = read; stable while dma_req.
- dma_address  in  32  DMA address; stable while dma_req.
- dma_writedata  in  32  DMA write data; stable while dma_req.
- dma_readdata  out  32  read data captured on grant; held until next grant.
- dma_ack  out  1  one-cycle completion pulse.
- mem_address, mem_writedata  out  32  to data memory.
- mem_write, mem_read  out  1  to data memory.
- mem_clk_enable  out  1  equals clk_enable.
- mem_readdata  in  32  memory read data, valid combinationally in the access cycle.

## Operation
- States: IDLE, STEAL, ACK. Reset: IDLE, starve_cnt=0, dma_ack=0, dma_readdata=0.
- cpu_busy = cpu_data_read | cpu_data_write.
- IDLE, dma_req=0: memory port muxed to CPU; starve_cnt cleared.
- IDLE, dma_req=1, cpu_busy=0: DMA granted this cycle (mem_* driven from dma_*, mem_read=!dma_write); at the edge capture mem_readdata into dma_readdata (reads only), clear starve_cnt, go ACK.
- IDLE, dma_req=1, cpu_busy=1: CPU routed. If starve_cnt==STARVE_LIMIT-1, go STEAL; else starve_cnt++.
- STEAL: cpu_clk_enable=0; memory routed to DMA regardless of CPU strobes; capture as above, clear starve_cnt, go ACK.
- ACK: dma_ack=1; memory routed to CPU; no DMA grant; go IDLE. The requester drops dma_req or presents a new request in the following cycle.
- cpu_clk_enable = clk_enable, except 0 in STEAL.
- dma_req dropped before grant: request withdrawn, starve_cnt cleared, no ack.
- Starve limit reached while cpu_busy=0: normal grant, no steal.
- clk_enable=0: state, counter, and dma_readdata hold; dma_ack holds its value; no memory write takes effect.
- Reset mid-operation (any state): immediate return to reset values; an in-flight DMA access is dropped without ack.

## Timing
- Uncontended DMA: grant in cycle N, dma_ack high in N+1.
- Contended DMA: worst case STARVE_LIMIT CPU cycles, then STEAL, then ACK (STARVE_LIMIT+2 cycles from request to ack).
- Mux select and cpu_clk_enable are decoded from registered state plus current inputs, with no added latency to CPU accesses.
- Back-to-back DMA: minimum two cycles per access (grant, ack).

## Configuration
- MIPS_ARB_STARVE_EN defined: starve_cnt and STEAL behave as above.
- Undefined: no counter and no STEAL state; cpu_clk_enable = clk_enable always; DMA is granted only in CPU-idle cycles and may wait indefinitely.

## Test plan
- After reset: dma_ack=0, dma_readdata=0, cpu_clk_enable=1. CPU sw 0xFFFF0 to 0x10, then lw from 0x10 -> cpu_data_readdata=0x000FFFF0.
- CPU idle, DMA writes 0xDEADBEEF to 0x20, then DMA reads 0x20 -> dma_ack one cycle after each grant; dma_readdata=0xDEADBEEF.
- STARVE_LIMIT=4, CPU reads every cycle, DMA read asserted at cycle 0 -> cycles 0-3 CPU served, cycle 4 cpu_clk_enable=0 with DMA on the memory, dma_ack at cycle 5.
- Without MIPS_ARB_STARVE_EN, same stimulus for 50 cycles -> no ack, cpu_clk_enable always 1; CPU goes idle -> grant then ack in the next cycle.
- clk_enable=0 for 3 cycles during STEAL -> state held, no ack until clk_enable returns; reset asserted in ACK -> dma_ack drops asynchronously.
